// File: rtl/cpu_pkg.sv
// Shared CPU definitions: instruction width, opcode/function codes, fetch
// buffer entry layout and the fetch-stage state encoding.
package cpu_pkg;

    localparam int INST_W = 32;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] FN_JR    = 6'h08;

    typedef struct packed {
        logic [INST_W-1:0] inst;
        logic [31:0]       pc;
    } fetch_entry_t;

    typedef enum logic {
        RUN  = 1'b0,
        HALT = 1'b1
    } fetch_state_t;

endpackage

// File: rtl/fetch_fifo2.sv
// Two-entry buffer of {inst, pc} between the BRAM return and decode.
// Flush wins over push; push and pop together keep the count unchanged.
import cpu_pkg::*;

module fetch_fifo2 (
    input  logic         clk,
    input  logic         rstn,
    input  logic         push,
    input  logic         pop,
    input  logic         flush,
    input  fetch_entry_t din,
    output fetch_entry_t head,
    output logic [1:0]   count
);

    fetch_entry_t e0;
    fetch_entry_t e1;
    logic         eff_pop;

    assign eff_pop = pop && (count != 2'd0);
    assign head    = e0;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            e0    <= '0;
            e1    <= '0;
            count <= 2'd0;
        end else if (flush) begin
            count <= 2'd0;
        end else begin
            case ({push, eff_pop})
                2'b10: begin
                    if (count == 2'd0) e0 <= din;
                    else               e1 <= din;
                    if (count != 2'd2) count <= count + 2'd1;
                end
                2'b01: begin
                    e0    <= e1;
                    count <= count - 2'd1;
                end
                2'b11: begin
                    // Head leaves; the new entry lands behind whatever remains.
                    if (count == 2'd1) begin
                        e0 <= din;
                    end else begin
                        e0 <= e1;
                        e1 <= din;
                    end
                end
                default: ;
            endcase
        end
    end

`ifndef SYNTHESIS
    a_no_overflow: assert property (@(posedge clk) disable iff (!rstn)
        !(push && !eff_pop && !flush && count == 2'd2));
`endif

endmodule

// File: rtl/inst_fetch.sv
// Instruction fetch: owns the PC, reads the 1-cycle BRAM and hands {inst, pc}
// to decode over valid/ready. Optional counters under INST_FETCH_PERF_CNT_EN.
import cpu_pkg::*;

module inst_fetch #(
    parameter int          INST_SIZE = 10,
    parameter logic [31:0] RESET_PC  = 32'h0
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic                 halt,
    input  logic                 redirect_valid,
    input  logic [31:0]          redirect_pc,
    output logic                 imem_en,
    output logic [INST_SIZE-1:0] imem_addr,
    input  logic [31:0]          imem_dout,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [31:0]          out_inst,
    output logic [31:0]          out_pc,
    output logic                 halted,
    output fetch_state_t         dbg_state
`ifdef INST_FETCH_PERF_CNT_EN
    ,
    output logic [31:0]          fetch_count,
    output logic [15:0]          squash_count
`endif
);

    // Handshake: a transfer happens on a clock edge where out_valid and
    // out_ready are both high; out_valid/out_inst/out_pc hold until then.

    fetch_state_t state, state_next;
    logic [31:0]  pc;
    logic         inflight;
    logic [31:0]  inflight_pc;
    logic [1:0]   count;
    fetch_entry_t head;
    fetch_entry_t din;
    logic         pop;
    logic         push;
    logic         issue;
    logic [2:0]   occupancy;

    fetch_fifo2 u_fifo (
        .clk   (clk),
        .rstn  (rstn),
        .push  (push),
        .pop   (pop),
        .flush (redirect_valid),
        .din   (din),
        .head  (head),
        .count (count)
    );

    assign out_valid = (count != 2'd0);
    assign out_inst  = head.inst;
    assign out_pc    = head.pc;
    assign pop       = out_valid && out_ready;

    // Slots already committed (buffered + in flight) once this cycle's pop leaves.
    assign occupancy = {1'b0, count} + {2'b00, inflight} - {2'b00, pop};
    assign issue     = rstn && (state == RUN) && !redirect_valid && !halt
                       && (occupancy < 3'd2);
    assign imem_en   = issue;
    assign imem_addr = pc[INST_SIZE-1:0];

    assign push      = inflight && !redirect_valid;
    assign din.inst  = imem_dout;
    assign din.pc    = inflight_pc;

    assign halted    = (state == HALT) && !inflight;
    assign dbg_state = state;

    always_comb begin
        state_next = state;
        case (state)
            RUN:  if (halt) state_next = HALT;
            HALT: if (redirect_valid && !halt) state_next = RUN;
            default: state_next = RUN;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state       <= RUN;
            pc          <= RESET_PC;
            inflight    <= 1'b0;
            inflight_pc <= 32'h0;
        end else begin
            state <= state_next;
            if (redirect_valid) begin
                pc       <= redirect_pc;
                inflight <= 1'b0;
            end else if (issue) begin
                pc          <= pc + 32'd1;
                inflight    <= 1'b1;
                inflight_pc <= pc;
            end else begin
                inflight <= 1'b0;
            end
        end
    end

`ifdef INST_FETCH_PERF_CNT_EN
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            fetch_count  <= 32'h0;
            squash_count <= 16'h0;
        end else begin
            if (pop) fetch_count <= fetch_count + 32'd1;
            if (redirect_valid && (inflight || count != 2'd0) && squash_count != 16'hFFFF)
                squash_count <= squash_count + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_inst_fetch.sv
// Bench for inst_fetch: queue-based fetch model checked every cycle plus
// directed scenarios with literal expectations.
module tb_inst_fetch;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- DUT 1 (defaults) ----------------
    logic        rstn, halt, redirect_valid, out_ready;
    logic [31:0] redirect_pc;
    logic        imem_en;
    logic [9:0]  imem_addr;
    logic [31:0] imem_dout = 32'h0;
    logic        out_valid, halted;
    logic [31:0] out_inst, out_pc;
    cpu_pkg::fetch_state_t dbg_state;
`ifdef INST_FETCH_PERF_CNT_EN
    logic [31:0] fetch_count;
    logic [15:0] squash_count;
`endif

    inst_fetch dut (
        .clk(clk), .rstn(rstn), .halt(halt),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .imem_en(imem_en), .imem_addr(imem_addr), .imem_dout(imem_dout),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_inst(out_inst), .out_pc(out_pc),
        .halted(halted), .dbg_state(dbg_state)
`ifdef INST_FETCH_PERF_CNT_EN
        , .fetch_count(fetch_count), .squash_count(squash_count)
`endif
    );

    // ---------------- DUT 2 (small address space) ----------------
    logic        rstn2;
    logic        imem_en2;
    logic [3:0]  imem_addr2;
    logic [31:0] imem_dout2 = 32'h0;
    logic        out_valid2, halted2;
    logic [31:0] out_inst2, out_pc2;
    cpu_pkg::fetch_state_t dbg_state2;
`ifdef INST_FETCH_PERF_CNT_EN
    logic [31:0] fetch_count2;
    logic [15:0] squash_count2;
`endif

    inst_fetch #(.INST_SIZE(4), .RESET_PC(32'd14)) dut2 (
        .clk(clk), .rstn(rstn2), .halt(1'b0),
        .redirect_valid(1'b0), .redirect_pc(32'h0),
        .imem_en(imem_en2), .imem_addr(imem_addr2), .imem_dout(imem_dout2),
        .out_valid(out_valid2), .out_ready(1'b1),
        .out_inst(out_inst2), .out_pc(out_pc2),
        .halted(halted2), .dbg_state(dbg_state2)
`ifdef INST_FETCH_PERF_CNT_EN
        , .fetch_count(fetch_count2), .squash_count(squash_count2)
`endif
    );

    // Synchronous BRAMs: memory[i] = base + i
    always @(posedge clk) if (imem_en)  imem_dout  <= 32'h2000_0000 + {22'b0, imem_addr};
    always @(posedge clk) if (imem_en2) imem_dout2 <= 32'h3000_0000 + {28'b0, imem_addr2};

    // ---------------- scoreboard ----------------
    int tests = 0;
    int fails = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] mem_word(input logic [31:0] pc);
        return 32'h2000_0000 + {22'b0, pc[9:0]};
    endfunction

    // Model: buffered {inst, pc} entries, one optional outstanding read, run flag.
    logic [63:0] exp_q[$];
    bit          m_run;
    bit          m_infl;
    logic [31:0] m_infl_pc;
    logic [31:0] m_pc;
    logic [31:0] m_pops;
    logic [15:0] m_squash;

    function automatic bit m_issue();
        int committed;
        committed = exp_q.size() + int'(m_infl) - ((exp_q.size() != 0 && out_ready) ? 1 : 0);
        return rstn && m_run && !redirect_valid && !halt && committed < 2;
    endfunction

    always @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            exp_q.delete();
            m_run = 1; m_infl = 0; m_infl_pc = 0; m_pc = 32'h0;
            m_pops = 0; m_squash = 0;
        end else begin
            bit iss, pp;
            iss = m_issue();
            pp  = (exp_q.size() != 0) && out_ready;
            if (pp) m_pops = m_pops + 1;
            if (redirect_valid) begin
                if ((m_infl || exp_q.size() != 0) && m_squash != 16'hFFFF) m_squash = m_squash + 1;
                exp_q.delete();
                m_infl = 0;
                m_pc = redirect_pc;
            end else begin
                if (pp) void'(exp_q.pop_front());
                if (m_infl) exp_q.push_back({mem_word(m_infl_pc), m_infl_pc});
                if (exp_q.size() > 2) check("model_space", exp_q.size(), 2);
                m_infl = iss;
                if (iss) begin
                    m_infl_pc = m_pc;
                    m_pc = m_pc + 1;
                end
            end
            m_run = halt ? 1'b0 : (redirect_valid ? 1'b1 : m_run);
        end
    end

    always @(negedge clk) begin
        if (!rstn) begin
            check("rst_out_valid", 32'(out_valid), 32'd0);
            check("rst_imem_en",   32'(imem_en),   32'd0);
            check("rst_halted",    32'(halted),    32'd0);
        end else begin
            check("out_valid", 32'(out_valid), 32'(exp_q.size() != 0));
            if (exp_q.size() != 0) begin
                check("out_pc",   out_pc,   exp_q[0][31:0]);
                check("out_inst", out_inst, exp_q[0][63:32]);
            end
            check("imem_en", 32'(imem_en), 32'(m_issue()));
            if (imem_en) check("imem_addr", {22'b0, imem_addr}, {22'b0, m_pc[9:0]});
            check("halted", 32'(halted), 32'(!m_run && !m_infl));
`ifdef INST_FETCH_PERF_CNT_EN
            check("fetch_count",  fetch_count, m_pops);
            check("squash_count", {16'b0, squash_count}, {16'b0, m_squash});
`endif
        end
    end

    // ---------------- driver tasks ----------------
    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_redirect(input logic [31:0] target, input logic with_halt);
        redirect_valid = 1'b1;
        redirect_pc    = target;
        halt           = with_halt;
        step(1);
        redirect_valid = 1'b0;
        halt           = 1'b0;
    endtask

    logic [31:0] addr_log[$];
    logic [31:0] pc_log[$];
    logic [31:0] inst_log[$];
    logic [31:0] exp_addr2[4] = '{32'd14, 32'd15, 32'd0, 32'd1};
    logic [31:0] exp_pc2[4]   = '{32'd14, 32'd15, 32'd16, 32'd17};
    logic [31:0] exp_inst2[4] = '{32'h3000_000E, 32'h3000_000F, 32'h3000_0000, 32'h3000_0001};
    logic [15:0] ready_pat    = 16'b1011_0010_1110_0110;

    initial begin
        rstn = 1'b0; rstn2 = 1'b0;
        halt = 1'b0; redirect_valid = 1'b0; redirect_pc = 32'h0; out_ready = 1'b1;
        step(2);
        check("reset_out_valid", 32'(out_valid), 32'd0);
        check("reset_out_pc",    out_pc,         32'd0);
        check("reset_out_inst",  out_inst,       32'd0);
        check("reset_imem_en",   32'(imem_en),   32'd0);
        check("reset_halted",    32'(halted),    32'd0);

        // Narrow address space: address wraps, PC does not.
        rstn2 = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (imem_en2)   addr_log.push_back({28'b0, imem_addr2});
            if (out_valid2) begin
                pc_log.push_back(out_pc2);
                inst_log.push_back(out_inst2);
            end
        end
        check("wrap_addr_count", (addr_log.size() >= 4) ? 32'd4 : addr_log.size(), 32'd4);
        check("wrap_pc_count",   (pc_log.size()   >= 4) ? 32'd4 : pc_log.size(),   32'd4);
        for (int i = 0; i < 4; i++) begin
            if (i < addr_log.size()) check("wrap_imem_addr", addr_log[i], exp_addr2[i]);
            if (i < pc_log.size()) begin
                check("wrap_out_pc",   pc_log[i],   exp_pc2[i]);
                check("wrap_out_inst", inst_log[i], exp_inst2[i]);
            end
        end

        // Main stream from RESET_PC = 0
        @(posedge clk); #1;
        rstn = 1'b1;
        step(2);
        check("first_valid", 32'(out_valid), 32'd1);
        check("first_pc",    out_pc,         32'h0);
        check("first_inst",  out_inst,       32'h2000_0000);
        step(3);
        check("pre_stall_pc", out_pc, 32'd3);

        out_ready = 1'b0;
        step(5);
        check("stall_pc",      out_pc,         32'd3);
        check("stall_inst",    out_inst,       32'h2000_0003);
        check("stall_imem_en", 32'(imem_en),   32'd0);
        out_ready = 1'b1;
        step(2);
        check("pre_redirect_pc", out_pc, 32'd5);

        do_redirect(32'h40, 1'b0);
        check("redirect_flush_valid", 32'(out_valid), 32'd0);
        step(2);
        check("redirect_valid", 32'(out_valid), 32'd1);
        check("redirect_pc",    out_pc,         32'h40);
        check("redirect_inst",  out_inst,       32'h2000_0040);

        step(2);
        check("pre_halt_pc", out_pc, 32'h42);
        halt = 1'b1;
        #1;
        check("halt_imem_en", 32'(imem_en), 32'd0);
        step(3);
        check("halt_halted", 32'(halted),    32'd1);
        check("halt_drained", 32'(out_valid), 32'd0);
        halt = 1'b0;
        step(2);
        check("halt_stays", 32'(imem_en), 32'd0);
        do_redirect(32'h10, 1'b0);
        step(2);
        check("resume_pc",     out_pc,       32'h10);
        check("resume_halted", 32'(halted),  32'd0);

        step(3);
        do_redirect(32'h80, 1'b1);
        step(3);
        check("redir_halt_halted", 32'(halted),    32'd1);
        check("redir_halt_valid",  32'(out_valid), 32'd0);
        check("redir_halt_en",     32'(imem_en),   32'd0);
        do_redirect(32'h80, 1'b0);
        step(2);
        check("redir_halt_resume_pc", out_pc, 32'h80);

        for (int i = 0; i < 32; i++) begin
            out_ready = ready_pat[i % 16];
            step(1);
        end

        // Fill the buffer, then reset between clock edges.
        out_ready = 1'b0;
        step(3);
        check("full_valid",   32'(out_valid), 32'd1);
        check("full_imem_en", 32'(imem_en),   32'd0);
        #3;
        rstn = 1'b0;
        #1;
        check("async_rst_valid",   32'(out_valid), 32'd0);
        check("async_rst_imem_en", 32'(imem_en),   32'd0);
        @(posedge clk); #1;
        out_ready = 1'b1;
        rstn = 1'b1;
        step(2);
        check("post_rst_valid", 32'(out_valid), 32'd1);
        check("post_rst_pc",    out_pc,         32'h0);
        step(5);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
